// File: rtl/sobel_line_engine.sv
// Line-sequenced 3x3 Sobel engine: walks one line of windows from three row buffers and emits a
// saturated |Gx|+|Gy| magnitude plus threshold flag through a three-stage pipeline.
module sobel_line_engine #(
  parameter int unsigned IMG_W = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_go,
  input  logic [7:0] t0,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  input  logic [7:0] m0,
  input  logic [7:0] m1,
  input  logic [7:0] m2,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] thresh,
  output logic       rd_en,
  output logic       ptr_rst,
  output logic       busy,
  output logic [7:0] mag,
  // "edge" is a reserved word, hence edge_flag
  output logic       edge_flag,
  output logic       out_valid,
  output logic       out_eol,
  output logic       line_done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [1:0]      drain_q, drain_d;
  logic            col_last;

  assign col_last = (col_q == ColLast);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (line_go) begin
          state_d = StRun;
          col_d   = '0;
        end
      end
      StRun: begin
        col_d = col_q + ColW'(1);
        if (col_last) begin
          state_d = StDrain;
          col_d   = '0;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  // Control outputs decode straight from the state register, so reset clears them on the edge.
  assign rd_en     = (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign ptr_rst   = (state_q == StDone);
  assign line_done = (state_q == StDone);

  // Stage 1: window capture
  logic       s1_valid_q, s1_eol_q;
  logic [7:0] s1_t0_q, s1_t1_q, s1_t2_q;
  logic [7:0] s1_m0_q, s1_m1_q, s1_m2_q;
  logic [7:0] s1_b0_q, s1_b1_q, s1_b2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_eol_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_en;
      s1_eol_q   <= rd_en & col_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      s1_t0_q <= t0;
      s1_t1_q <= t1;
      s1_t2_q <= t2;
      s1_m0_q <= m0;
      s1_m1_q <= m1;
      s1_m2_q <= m2;
      s1_b0_q <= b0;
      s1_b1_q <= b1;
      s1_b2_q <= b2;
    end
  end

  // The centre tap carries zero weight in both kernels.
  logic unused_center;
  assign unused_center = ^s1_m1_q;

  // Stage 2: gradients. Each weighted sum is at most 1020, so 10 bits unsigned and an 11-bit
  // signed difference never overflow.
  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_d, gy_d;
  logic signed [10:0] s2_gx_q, s2_gy_q;
  logic               s2_valid_q, s2_eol_q;

  assign gx_pos = {2'b00, s1_t2_q} + {1'b0, s1_m2_q, 1'b0} + {2'b00, s1_b2_q};
  assign gx_neg = {2'b00, s1_t0_q} + {1'b0, s1_m0_q, 1'b0} + {2'b00, s1_b0_q};
  assign gy_pos = {2'b00, s1_b0_q} + {1'b0, s1_b1_q, 1'b0} + {2'b00, s1_b2_q};
  assign gy_neg = {2'b00, s1_t0_q} + {1'b0, s1_t1_q, 1'b0} + {2'b00, s1_t2_q};
  assign gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_eol_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_eol_q   <= s1_valid_q & s1_eol_q;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      s2_gx_q <= gx_d;
      s2_gy_q <= gy_d;
    end
  end

  // Stage 3: magnitude, saturation, threshold
  logic signed [10:0] gx_negated, gy_negated;
  logic [9:0]         gx_abs, gy_abs;
  logic [10:0]        sum_abs;
  logic [7:0]         mag_sat;
  logic               edge_d;

  assign gx_negated = -s2_gx_q;
  assign gy_negated = -s2_gy_q;
  assign gx_abs     = s2_gx_q[10] ? gx_negated[9:0] : s2_gx_q[9:0];
  assign gy_abs     = s2_gy_q[10] ? gy_negated[9:0] : s2_gy_q[9:0];
  assign sum_abs    = {1'b0, gx_abs} + {1'b0, gy_abs};
  assign mag_sat    = (|sum_abs[10:8]) ? 8'hFF : sum_abs[7:0];
  assign edge_d     = (mag_sat >= thresh);

  logic [7:0] mag_q;
  logic       edge_q, out_valid_q, out_eol_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q       <= '0;
      edge_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      out_valid_q <= s2_valid_q;
      out_eol_q   <= s2_valid_q & s2_eol_q;
      if (s2_valid_q) begin
        mag_q  <= mag_sat;
        edge_q <= edge_d;
      end
    end
  end

  assign mag       = mag_q;
  assign edge_flag = edge_q;
  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;

endmodule

// File: doc/sobel_line_engine.md
SOBEL_LINE_ENGINE -- requirements
Module: sobel_line_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line and windows per line.
REQ-002 SHALL have input clk, 1 bit: clock; all logic on the rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input line_go, 1 bit: pulse meaning three row buffers are loaded and a line may be processed.
REQ-005 SHALL have inputs t0,t1,t2, 8 bits each: top-row adjacent pixels, left to right, combinational from the row buffer.
REQ-006 SHALL have inputs m0,m1,m2, 8 bits each: middle-row adjacent pixels.
REQ-007 SHALL have inputs b0,b1,b2, 8 bits each: bottom-row adjacent pixels.
REQ-008 SHALL have input thresh, 8 bits: edge threshold, sampled at pipeline stage 3.
REQ-009 SHALL have output rd_en, 1 bit: advances all three row-buffer read pointers by one.
REQ-010 SHALL have output ptr_rst, 1 bit: one-cycle pulse that returns the row-buffer read pointers to 0.
REQ-011 SHALL have output busy, 1 bit: high in every state except IDLE.
REQ-012 SHALL have output mag, 8 bits: saturated gradient magnitude.
REQ-013 SHALL have output edge, 1 bit: mag >= thresh.
REQ-014 SHALL have output out_valid, 1 bit: mag and edge are valid.
REQ-015 SHALL have output out_eol, 1 bit: marks the last pixel of the line, qualified by out_valid.
REQ-016 SHALL have output line_done, 1 bit: one-cycle pulse at end of line.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE SHALL go to RUN on line_go and clear the column counter; line_go SHALL be ignored in every other state.
REQ-019 RUN SHALL hold rd_en=1 every cycle, sample the 9-pixel window in that cycle, and increment col; when col==IMG_W-1 the FSM SHALL go to DRAIN.
REQ-020 rd_en SHALL be high exactly IMG_W consecutive cycles per line.
REQ-021 DRAIN SHALL last exactly 3 cycles with rd_en=0, then go to DONE.
REQ-022 DONE SHALL last 1 cycle with ptr_rst=1 and line_done=1, then go to IDLE.
REQ-023 Stage 1 SHALL register the 9 pixels, a valid bit, and eol = (col==IMG_W-1).
REQ-024 Stage 2 SHALL compute Gx = (t2+2*m2+b2) - (t0+2*m0+b0) and Gy = (b0+2*b1+b2) - (t0+2*t1+t2), each 11-bit signed, range -1020..1020, with no overflow.
REQ-025 Stage 3 SHALL compute |Gx|+|Gy| (11-bit unsigned, max 2040) and saturate values >255 to 255 to form mag.
REQ-026 Stage 3 SHALL set edge = (saturated mag >= thresh) and register mag, edge, out_valid and out_eol.
REQ-027 A window sampled with rd_en high in cycle t SHALL appear on the outputs in cycle t+3, in order, with no gaps.
REQ-028 line_done SHALL assert exactly one cycle after the out_eol cycle.
REQ-029 mag and edge SHALL hold their last value while out_valid=0; out_eol SHALL be 0 whenever out_valid=0.
REQ-030 thresh=0 SHALL give edge=1 for every valid pixel.
REQ-031 thresh=255 SHALL give edge=1 only when mag is saturated or exactly 255.

Reset
REQ-032 rst SHALL force state IDLE, col=0, all pipeline valid bits 0, and every output 0 (rd_en, ptr_rst, busy, mag, edge, out_valid, out_eol, line_done) on the next edge.
REQ-033 rst in RUN or DRAIN SHALL abort the line: no further out_valid, no line_done, and no ptr_rst (the row buffers share rst).
REQ-034 rst SHALL take precedence over line_go in the same cycle.

Verification
REQ-035 Bench SHALL drive a flat field, all pixels 50, then line_go -> 640 rd_en cycles, 640 contiguous out_valid starting 3 cycles after the first rd_en, all mag=0 and edge=0, out_eol on the 640th, line_done the next cycle, ptr_rst in that same cycle.
REQ-036 Bench SHALL drive t0=m0=b0=0, t2=m2=b2=255, middle column 128, thresh=200 -> Gx=1020, Gy=0, mag=255 (saturated), edge=1.
REQ-037 Bench SHALL drive a window giving Gx=40, Gy=-30 -> mag=70; with thresh=70 edge=1, with thresh=71 edge=0.
REQ-038 Bench SHALL pulse line_go repeatedly during RUN, DRAIN and DONE -> ignored; rd_en count per line exactly 640, one line_done.
REQ-039 Bench SHALL assert rst at column 300 -> next cycle rd_en=0, busy=0, out_valid=0, no line_done; a following line_go processes a full 640 pixels.
REQ-040 Bench SHALL issue back-to-back lines with line_go on the first IDLE cycle after DONE -> second line accepted, 1280 total valid outputs, two line_done pulses.
